triangle_classifier: RTL and testbench

Parametrised Avalon-MM slave that classifies a triangle from three side lengths written by the host. Adds an explicit start/busy/done flow, overflow-safe arithmetic, full classification (valid/equilateral/isosceles/scalene/degenerate), a completion counter and an interrupt. Sits on the system Avalon interconnect as a memory-mapped accelerator next to the other Avalon slave IPs.

---
 rtl/triangle_classifier_pkg.sv | 63 ++++++
 rtl/triangle_classifier_core.sv | 89 ++++++++
 rtl/triangle_classifier.sv | 84 ++++++++
 tb/tb_triangle_classifier.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/triangle_classifier_pkg.sv
// triangle_classifier_pkg: register map, bit indices and the shared classify helpers.
package triangle_classifier_pkg;
  localparam logic [2:0] ADDR_A      = 3'd0;
  localparam logic [2:0] ADDR_B      = 3'd1;
  localparam logic [2:0] ADDR_C      = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_RESULT = 3'd5;
  localparam logic [2:0] ADDR_COUNT  = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int RES_VALID = 0;
  localparam int RES_EQU   = 1;
  localparam int RES_ISO   = 2;
  localparam int RES_SCA   = 3;
  localparam int RES_DEG   = 4;
  localparam int RES_W     = 5;
  // Widest side is 32 bits, so 33-bit sums can never overflow.
  localparam int SUM_W = 33;
  localparam logic [31:0] RSVD_READ = 32'hFFFF_FFFF;
  typedef struct packed {
    logic gt_ab_c;
    logic gt_ac_b;
    logic gt_bc_a;
    logic eq_ab_c;
    logic eq_ac_b;
    logic eq_bc_a;
    logic nz;
    logic eq_ab;
    logic eq_bc;
    logic eq_ac;
  } tri_cmp_t;
  function automatic tri_cmp_t tri_compare(input logic [SUM_W-1:0] sab, sac, sbc, a, b, c);
    tri_cmp_t t;
    t.gt_ab_c = sab > c;
    t.gt_ac_b = sac > b;
    t.gt_bc_a = sbc > a;
    t.eq_ab_c = sab == c;
    t.eq_ac_b = sac == b;
    t.eq_bc_a = sbc == a;
    t.nz      = (a != '0) && (b != '0) && (c != '0);
    t.eq_ab   = a == b;
    t.eq_bc   = b == c;
    t.eq_ac   = a == c;
    return t;
  endfunction
  function automatic logic [RES_W-1:0] tri_classify(input tri_cmp_t t);
    logic [RES_W-1:0] r;
    logic v;
    v = t.gt_ab_c & t.gt_ac_b & t.gt_bc_a;
    r = '0;
    r[RES_VALID] = v;
    r[RES_EQU]   = v & t.eq_ab & t.eq_bc;
    r[RES_ISO]   = v & !(t.eq_ab & t.eq_bc) & (t.eq_ab | t.eq_bc | t.eq_ac);
    r[RES_SCA]   = v & !t.eq_ab & !t.eq_bc & !t.eq_ac;
    r[RES_DEG]   = !v & (t.eq_ab_c | t.eq_ac_b | t.eq_bc_a) & t.nz;
    return r;
  endfunction
endpackage

// File: rtl/triangle_classifier_core.sv
// tri_classify_core: snapshots three sides on i_start and returns the class with a one-cycle o_valid pulse.
module tri_classify_core
  import triangle_classifier_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PIPELINE = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_c,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result
);
  logic [DATA_W-1:0] r_a, r_b, r_c;
  logic r_v0;
  logic [SUM_W-1:0] w_a, w_b, w_c, w_sab, w_sac, w_sbc;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_v0 <= 1'b0;
    end else begin
      r_v0 <= i_start;
      if (i_start) begin
        r_a <= i_a;
        r_b <= i_b;
        r_c <= i_c;
      end
    end
  end
  assign w_a   = SUM_W'(r_a);
  assign w_b   = SUM_W'(r_b);
  assign w_c   = SUM_W'(r_c);
  assign w_sab = w_a + w_b;
  assign w_sac = w_a + w_c;
  assign w_sbc = w_b + w_c;
  generate
    if (PIPELINE == 0) begin : g_comb
      logic [RES_W-1:0] r_res;
      logic r_v;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_res <= '0;
          r_v   <= 1'b0;
        end else begin
          r_v <= r_v0;
          if (r_v0) r_res <= tri_classify(tri_compare(w_sab, w_sac, w_sbc, w_a, w_b, w_c));
        end
      end
      assign o_valid  = r_v;
      assign o_result = r_res;
    end else begin : g_pipe
      // Snapshot regs stay frozen while busy, so later stages may read them directly.
      logic [SUM_W-1:0] r_sab, r_sac, r_sbc;
      tri_cmp_t r_cmp;
      logic [RES_W-1:0] r_res;
      logic r_v1, r_v2, r_v3;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sab <= '0;
          r_sac <= '0;
          r_sbc <= '0;
          r_cmp <= '0;
          r_res <= '0;
          r_v1  <= 1'b0;
          r_v2  <= 1'b0;
          r_v3  <= 1'b0;
        end else begin
          r_v1 <= r_v0;
          r_v2 <= r_v1;
          r_v3 <= r_v2;
          if (r_v0) begin
            r_sab <= w_sab;
            r_sac <= w_sac;
            r_sbc <= w_sbc;
          end
          if (r_v1) r_cmp <= tri_compare(r_sab, r_sac, r_sbc, w_a, w_b, w_c);
          if (r_v2) r_res <= tri_classify(r_cmp);
        end
      end
      assign o_valid  = r_v3;
      assign o_result = r_res;
    end
  endgenerate
endmodule

// File: rtl/triangle_classifier.sv
// triangle_classifier: Avalon-MM register file, start/busy/done/err control, completion count and irq.
module triangle_classifier
  import triangle_classifier_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PIPELINE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        irq
);
  logic [DATA_W-1:0] r_a, r_b, r_c;
  logic r_irq_en, r_busy, r_done, r_err;
  logic [RES_W-1:0] r_result;
  logic [31:0] r_count;
  logic w_start, w_go, w_st_wr, w_core_valid;
  logic [RES_W-1:0] w_core_result;
  logic [31:0] w_rd_mux;
  assign w_start = write && address == ADDR_CTRL && writedata[CTRL_START];
  assign w_go    = w_start && !r_busy;
  assign w_st_wr = write && address == ADDR_STATUS;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_irq_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_count  <= '0;
    end else begin
      if (write && address == ADDR_A) r_a <= writedata[DATA_W-1:0];
      if (write && address == ADDR_B) r_b <= writedata[DATA_W-1:0];
      if (write && address == ADDR_C) r_c <= writedata[DATA_W-1:0];
      if (write && address == ADDR_CTRL) r_irq_en <= writedata[CTRL_IRQ_EN];
      r_busy <= w_go | (r_busy & !w_core_valid);
      // Setting events take priority over the W1C clear on the same edge.
      r_done <= w_core_valid | (r_done & !w_go & !(w_st_wr & writedata[ST_DONE]));
      r_err  <= (w_start & r_busy) | (r_err & !(w_st_wr & writedata[ST_ERR]));
      if (w_core_valid) begin
        r_result <= w_core_result;
        r_count  <= r_count + 32'd1;
      end
    end
  end
  tri_classify_core #(.DATA_W(DATA_W), .PIPELINE(PIPELINE)) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_go),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_c      (r_c),
    .o_valid  (w_core_valid),
    .o_result (w_core_result)
  );
  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_A:      w_rd_mux = 32'(r_a);
      ADDR_B:      w_rd_mux = 32'(r_b);
      ADDR_C:      w_rd_mux = 32'(r_c);
      ADDR_CTRL:   w_rd_mux[CTRL_IRQ_EN] = r_irq_en;
      ADDR_STATUS: begin
        w_rd_mux[ST_BUSY] = r_busy;
        w_rd_mux[ST_DONE] = r_done;
        w_rd_mux[ST_ERR]  = r_err;
      end
      ADDR_RESULT: w_rd_mux[RES_W-1:0] = r_result;
      ADDR_COUNT:  w_rd_mux = r_count;
      default:     w_rd_mux = RSVD_READ;
    endcase
  end
  assign waitrequest = read && address == ADDR_RESULT && r_busy;
  assign readdata    = (read && !waitrequest) ? w_rd_mux : '0;
  assign irq         = r_done & r_irq_en;
endmodule

// File: tb/tb_triangle_classifier.sv
// tb_triangle_classifier: directed scoreboard bench driving a PIPELINE=1/DATA_W=32 and a PIPELINE=0/DATA_W=8 instance in parallel.
module tb_triangle_classifier;
  import triangle_classifier_pkg::*;
  logic clk, reset_n, read, write;
  logic [2:0] address;
  logic [31:0] writedata, readdata, readdata8;
  logic waitrequest, waitrequest8, irq, irq8;
  int errors = 0, checks = 0, exp_count = 0;
  logic [4:0] sb[$];
  triangle_classifier #(.DATA_W(32), .PIPELINE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata), .irq(irq)
  );
  triangle_classifier #(.DATA_W(8), .PIPELINE(0)) dut8 (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .waitrequest(waitrequest8), .readdata(readdata8), .irq(irq8)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    @(posedge clk);
    #1 write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic [31:0] d8, output int stall);
    @(negedge clk);
    address = a; read = 1'b1; write = 1'b0;
    #1 stall = 0;
    while (waitrequest && stall < 50) begin
      @(negedge clk);
      #1 stall++;
    end
    d = readdata; d8 = readdata8;
    @(posedge clk);
    #1 read = 1'b0;
  endtask
  task automatic start(input logic [31:0] a, b, c, input logic [4:0] exp, input logic [31:0] ctrl);
    wr(ADDR_A, a);
    wr(ADDR_B, b);
    wr(ADDR_C, c);
    sb.push_back(exp);
    wr(ADDR_CTRL, ctrl);
  endtask
  task automatic finish_op(input string tag);
    logic [31:0] d, d8;
    logic [4:0] e;
    int s, n;
    n = 0;
    do begin
      rd(ADDR_STATUS, d, d8, s);
      n++;
    end while (d[ST_BUSY] && n < 40);
    chk({tag, "_idle"}, {31'b0, d[ST_BUSY]}, 32'd0);
    exp_count++;
    rd(ADDR_RESULT, d, d8, s);
    e = (sb.size() > 0) ? sb.pop_front() : 5'bxxxxx;
    chk(tag, d, {27'b0, e});
  endtask
  task automatic run(input logic [31:0] a, b, c, input logic [4:0] exp, input string tag);
    start(a, b, c, exp, 32'd1);
    finish_op(tag);
  endtask
  initial begin
    logic [31:0] d, d8;
    int s, n, n8;
    logic [4:0] e;
    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wait", {31'b0, waitrequest}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    rd(ADDR_STATUS, d, d8, s);
    chk("rst_status", d, 32'd0);
    rd(ADDR_COUNT, d, d8, s);
    chk("rst_count", d, 32'd0);
    start(32'd3, 32'd4, 32'd5, 5'h09, 32'd1);
    n = 0; n8 = 0;
    do begin
      rd(ADDR_STATUS, d, d8, s);
      n += int'(d[ST_BUSY]);
      n8 += int'(d8[ST_BUSY]);
    end while (d[ST_BUSY] && n < 40);
    chk("busy_len_p1", n, 32'd4);
    chk("busy_len_p0", n8, 32'd2);
    chk("status_done", d, 32'h2);
    chk("status_done_w8", d8, 32'h2);
    exp_count++;
    rd(ADDR_RESULT, d, d8, s);
    e = (sb.size() > 0) ? sb.pop_front() : 5'bxxxxx;
    chk("res_345", d, {27'b0, e});
    chk("res_345_w8", d8, 32'h09);
    rd(ADDR_COUNT, d, d8, s);
    chk("count_1", d, exp_count);
    run(32'd5, 32'd5, 32'd5, 5'h03, "res_555");
    run(32'd5, 32'd5, 32'd8, 5'h05, "res_558");
    run(32'd1, 32'd2, 32'd3, 5'h10, "res_123");
    run(32'd1, 32'd2, 32'd10, 5'h00, "res_1210");
    run(32'd0, 32'd0, 32'd0, 5'h00, "res_000");
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 5'h05, "res_ovf");
    wr(ADDR_A, 32'h1FF);
    rd(ADDR_A, d, d8, s);
    chk("a_rb_w32", d, 32'h1FF);
    chk("a_rb_w8", d8, 32'hFF);
    rd(ADDR_RSVD, d, d8, s);
    chk("rsvd", d, 32'hFFFF_FFFF);
    start(32'd5, 32'd5, 32'd5, 5'h03, 32'd1);
    @(posedge clk);
    rd(ADDR_RESULT, d, d8, s);
    exp_count++;
    e = (sb.size() > 0) ? sb.pop_front() : 5'bxxxxx;
    chk("stall_len", s, 32'd3);
    chk("stall_res", d, {27'b0, e});
    start(32'd3, 32'd4, 32'd5, 5'h09, 32'd1);
    wr(ADDR_A, 32'd5);
    wr(ADDR_CTRL, 32'd1);
    finish_op("err_res");
    rd(ADDR_STATUS, d, d8, s);
    chk("err_status", d, 32'h6);
    wr(ADDR_STATUS, 32'h6);
    rd(ADDR_STATUS, d, d8, s);
    chk("w1c_status", d, 32'h0);
    rd(ADDR_COUNT, d, d8, s);
    chk("count_n", d, exp_count);
    wr(ADDR_CTRL, 32'd2);
    chk("irq_idle", {31'b0, irq}, 32'd0);
    rd(ADDR_CTRL, d, d8, s);
    chk("ctrl_rb", d, 32'h2);
    start(32'd5, 32'd8, 32'd5, 5'h05, 32'd3);
    finish_op("irq_res");
    chk("irq_set", {31'b0, irq}, 32'd1);
    wr(ADDR_STATUS, 32'h2);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    wr(ADDR_A, 32'd3);
    wr(ADDR_CTRL, 32'd1);
    repeat (2) @(posedge clk);
    #2 address = ADDR_STATUS; read = 1'b1;
    #1 chk("pre_rst_busy", readdata, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdata", readdata, 32'd0);
    chk("mid_rst_wait", {31'b0, waitrequest}, 32'd0);
    chk("mid_rst_irq", {31'b0, irq}, 32'd0);
    read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_count = 0;
    repeat (6) @(posedge clk);
    rd(ADDR_STATUS, d, d8, s);
    chk("post_rst_status", d, 32'd0);
    rd(ADDR_COUNT, d, d8, s);
    chk("post_rst_count", d, 32'd0);
    force dut.r_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.r_count;
    rd(ADDR_COUNT, d, d8, s);
    chk("count_max", d, 32'hFFFF_FFFF);
    run(32'd5, 32'd5, 32'd8, 5'h05, "res_wrap");
    rd(ADDR_COUNT, d, d8, s);
    chk("count_wrap", d, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
